// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : render_pkg
//  Description : Shared definitions for the render scheduler: screen limits,
//                coordinate/colour/size widths, FSM state encoding and the
//                default (black) background colour.
//  Revision    : 1.0 - initial release
// ============================================================================
package render_pkg;

  localparam int SCREEN_W = 160;  // visible width in pixels
  localparam int SCREEN_H = 120;  // visible height in pixels

  localparam int X_W    = 8;      // pixel X width
  localparam int Y_W    = 7;      // pixel Y width
  localparam int COL_W  = 3;      // RGB colour width
  localparam int SIZE_W = 3;      // square side width

  localparam logic [COL_W-1:0] BG_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LATCH     = 3'd1,
    ST_ERASE_SEL = 3'd2,
    ST_ERASE_PIX = 3'd3,
    ST_DRAW_SEL  = 3'd4,
    ST_DRAW_PIX  = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/box_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : box_scanner
//  Description : Raster-scans a size x size square starting at (base_x,
//                base_y), one pixel per cycle, row-major with X fastest.
//                Pixels that fall off-screen still take their cycle but are
//                emitted with plot low.
//  Ports       : clk, reset      - clock, async active-high reset
//                start_i         - load base/size/colour, first pixel next cycle
//                base_x_i/y_i    - top-left corner of the box
//                size_i          - side length (must be non-zero on start)
//                colour_i        - colour attached to every pixel
//                pix_x_o/y_o     - registered pixel coordinate
//                pix_colour_o    - registered pixel colour
//                plot_o          - registered write strobe (on-screen pixel)
//                done_o          - high while the last pixel is on the outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module box_scanner #(
  parameter int SCREEN_W = render_pkg::SCREEN_W,
  parameter int SCREEN_H = render_pkg::SCREEN_H
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic [render_pkg::X_W-1:0]    base_x_i,
  input  logic [render_pkg::Y_W-1:0]    base_y_i,
  input  logic [render_pkg::SIZE_W-1:0] size_i,
  input  logic [render_pkg::COL_W-1:0]  colour_i,
  output logic [render_pkg::X_W-1:0]    pix_x_o,
  output logic [render_pkg::Y_W-1:0]    pix_y_o,
  output logic [render_pkg::COL_W-1:0]  pix_colour_o,
  output logic                          plot_o,
  output logic                          done_o
);
  import render_pkg::*;

  localparam int          SW    = SCREEN_W;
  localparam int          SH    = SCREEN_H;
  localparam logic [X_W:0] X_LIM = SW[X_W:0];
  localparam logic [Y_W:0] Y_LIM = SH[Y_W:0];

  logic              active_q, active_d;
  logic [SIZE_W-1:0] px_q, px_d, py_q, py_d, size_q, size_d;
  logic [X_W-1:0]    bx_q, bx_d;
  logic [Y_W-1:0]    by_q, by_d;
  logic [COL_W-1:0]  colour_q, colour_d;

  logic [X_W-1:0]    pix_x_q;
  logic [Y_W-1:0]    pix_y_q;
  logic [COL_W-1:0]  pix_colour_q;
  logic              plot_q;

  logic              last_pix;
  logic [X_W:0]      sum_x;
  logic [Y_W:0]      sum_y;

  // The pixel currently on the outputs is the final one of the box.
  assign last_pix = active_q && (px_q == size_q - 1'b1) && (py_q == size_q - 1'b1);

  always_comb begin
    active_d = active_q;
    px_d     = px_q;
    py_d     = py_q;
    bx_d     = bx_q;
    by_d     = by_q;
    size_d   = size_q;
    colour_d = colour_q;
    if (start_i) begin
      active_d = 1'b1;
      px_d     = '0;
      py_d     = '0;
      bx_d     = base_x_i;
      by_d     = base_y_i;
      size_d   = size_i;
      colour_d = colour_i;
    end else if (active_q) begin
      if (last_pix) begin
        active_d = 1'b0;
      end else if (px_q == size_q - 1'b1) begin
        px_d = '0;
        py_d = py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
    // One extra bit so coordinates past the right/bottom edge do not wrap.
    sum_x = {1'b0, bx_d} + {{(X_W + 1 - SIZE_W){1'b0}}, px_d};
    sum_y = {1'b0, by_d} + {{(Y_W + 1 - SIZE_W){1'b0}}, py_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q     <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      size_q       <= '0;
      colour_q     <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_colour_q <= '0;
      plot_q       <= 1'b0;
    end else begin
      active_q     <= active_d;
      px_q         <= px_d;
      py_q         <= py_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      size_q       <= size_d;
      colour_q     <= colour_d;
      pix_x_q      <= sum_x[X_W-1:0];
      pix_y_q      <= sum_y[Y_W-1:0];
      pix_colour_q <= colour_d;
      plot_q       <= active_d && (sum_x < X_LIM) && (sum_y < Y_LIM);
    end
  end

  assign pix_x_o      = pix_x_q;
  assign pix_y_o      = pix_y_q;
  assign pix_colour_o = pix_colour_q;
  assign plot_o       = plot_q;
  assign done_o       = last_pix;

endmodule
`default_nettype wire

// File: rtl/render_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : render_scheduler
//  Description : Per frame tick, snapshots all object positions, then streams
//                VGA pixel writes in two passes: erase every moved object at
//                its previous box (background colour), then draw every moved
//                or new object at its current box.
//  Ports       : clk, reset          - clock, async active-high reset
//                tick                - one-cycle frame request
//                obj_x/y/size/colour - packed per-object inputs (object 0 =
//                                      player); size 0 disables an object
//                bg_colour           - erase colour
//                vga_x/y/colour,plot - registered pixel write port
//                busy                - frame in progress
//                frame_done          - one-cycle end-of-frame pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module render_scheduler #(
  parameter int N_OBJ    = 4,
  parameter int SCREEN_W = render_pkg::SCREEN_W,
  parameter int SCREEN_H = render_pkg::SCREEN_H
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                tick,
  input  logic [render_pkg::X_W*N_OBJ-1:0]    obj_x,
  input  logic [render_pkg::Y_W*N_OBJ-1:0]    obj_y,
  input  logic [render_pkg::SIZE_W*N_OBJ-1:0] obj_size,
  input  logic [render_pkg::COL_W*N_OBJ-1:0]  obj_colour,
  input  logic [render_pkg::COL_W-1:0]        bg_colour,
  output logic [render_pkg::X_W-1:0]          vga_x,
  output logic [render_pkg::Y_W-1:0]          vga_y,
  output logic [render_pkg::COL_W-1:0]        vga_colour,
  output logic                                plot,
  output logic                                busy,
  output logic                                frame_done
);
  import render_pkg::*;

  localparam int               IDX_W    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              pending_q;
  logic              busy_q;
  logic              frame_done_q;
  logic [N_OBJ-1:0]  prev_valid_q;

  // Snapshot of the current frame and record of what is on screen now.
  logic [X_W-1:0]    cur_x_q      [N_OBJ];
  logic [Y_W-1:0]    cur_y_q      [N_OBJ];
  logic [SIZE_W-1:0] cur_size_q   [N_OBJ];
  logic [COL_W-1:0]  cur_colour_q [N_OBJ];
  logic [COL_W-1:0]  cur_bg_q;
  logic [X_W-1:0]    prev_x_q     [N_OBJ];
  logic [Y_W-1:0]    prev_y_q     [N_OBJ];
  logic [SIZE_W-1:0] prev_size_q  [N_OBJ];

  logic              changed;
  logic              erase_need;
  logic              draw_need;
  logic              is_last;
  logic              scan_start;
  logic              scan_done;
  logic              erase_pass;
  logic [X_W-1:0]    scan_x;
  logic [Y_W-1:0]    scan_y;
  logic [SIZE_W-1:0] scan_size;
  logic [COL_W-1:0]  scan_colour;

  always_comb begin
    changed    = (cur_x_q[idx_q]    != prev_x_q[idx_q])  ||
                 (cur_y_q[idx_q]    != prev_y_q[idx_q])  ||
                 (cur_size_q[idx_q] != prev_size_q[idx_q]);
    // Colour is deliberately excluded from 'changed': recolouring alone
    // does not trigger a redraw.
    erase_need = prev_valid_q[idx_q] && (prev_size_q[idx_q] != '0) && changed;
    draw_need  = (cur_size_q[idx_q] != '0) && (!prev_valid_q[idx_q] || changed);
    is_last    = (idx_q == LAST_IDX);
    erase_pass = (state_q == ST_ERASE_SEL);
    scan_start = (erase_pass && erase_need) ||
                 ((state_q == ST_DRAW_SEL) && draw_need);
    scan_x      = erase_pass ? prev_x_q[idx_q]    : cur_x_q[idx_q];
    scan_y      = erase_pass ? prev_y_q[idx_q]    : cur_y_q[idx_q];
    scan_size   = erase_pass ? prev_size_q[idx_q] : cur_size_q[idx_q];
    scan_colour = erase_pass ? cur_bg_q           : cur_colour_q[idx_q];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (tick || pending_q) state_d = ST_LATCH;
      ST_LATCH:     state_d = ST_ERASE_SEL;
      ST_ERASE_SEL: begin
        if (erase_need)   state_d = ST_ERASE_PIX;
        else if (is_last) state_d = ST_DRAW_SEL;
      end
      // The last pixel of an object hands straight to the next object's
      // select cycle (or the draw pass), so no idle cycle is inserted.
      ST_ERASE_PIX: if (scan_done) state_d = is_last ? ST_DRAW_SEL : ST_ERASE_SEL;
      ST_DRAW_SEL: begin
        if (draw_need)    state_d = ST_DRAW_PIX;
        else if (is_last) state_d = ST_DONE;
      end
      ST_DRAW_PIX:  if (scan_done) state_d = is_last ? ST_DONE : ST_DRAW_SEL;
      ST_DONE:      state_d = (pending_q || tick) ? ST_LATCH : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      prev_valid_q <= '0;
      cur_bg_q     <= '0;
      for (int k = 0; k < N_OBJ; k++) begin
        cur_x_q[k]      <= '0;
        cur_y_q[k]      <= '0;
        cur_size_q[k]   <= '0;
        cur_colour_q[k] <= '0;
        prev_x_q[k]     <= '0;
        prev_y_q[k]     <= '0;
        prev_size_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= (state_d == ST_DONE);

      // Ticks seen in IDLE/DONE start a frame directly; any tick while a
      // frame is running is remembered once, extra ones are dropped.
      if ((state_q == ST_IDLE) || (state_q == ST_DONE)) pending_q <= 1'b0;
      else if (tick)                                    pending_q <= 1'b1;

      case (state_q)
        ST_LATCH: begin
          idx_q    <= '0;
          cur_bg_q <= bg_colour;
          for (int k = 0; k < N_OBJ; k++) begin
            cur_x_q[k]      <= obj_x[X_W*k +: X_W];
            cur_y_q[k]      <= obj_y[Y_W*k +: Y_W];
            cur_size_q[k]   <= obj_size[SIZE_W*k +: SIZE_W];
            cur_colour_q[k] <= obj_colour[COL_W*k +: COL_W];
          end
        end
        ST_ERASE_SEL: begin
          if (!erase_need) idx_q <= is_last ? '0 : idx_q + 1'b1;
        end
        ST_ERASE_PIX: begin
          if (scan_done) idx_q <= is_last ? '0 : idx_q + 1'b1;
        end
        ST_DRAW_SEL, ST_DRAW_PIX: begin
          // Object finished (skipped or fully drawn): record it as on-screen.
          if (((state_q == ST_DRAW_SEL) && !draw_need) ||
              ((state_q == ST_DRAW_PIX) && scan_done)) begin
            prev_x_q[idx_q]     <= cur_x_q[idx_q];
            prev_y_q[idx_q]     <= cur_y_q[idx_q];
            prev_size_q[idx_q]  <= cur_size_q[idx_q];
            prev_valid_q[idx_q] <= 1'b1;
            idx_q               <= is_last ? '0 : idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  box_scanner #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_box_scanner (
    .clk          (clk),
    .reset        (reset),
    .start_i      (scan_start),
    .base_x_i     (scan_x),
    .base_y_i     (scan_y),
    .size_i       (scan_size),
    .colour_i     (scan_colour),
    .pix_x_o      (vga_x),
    .pix_y_o      (vga_y),
    .pix_colour_o (vga_colour),
    .plot_o       (plot),
    .done_o       (scan_done)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_render_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_render_scheduler
//  Description : Self-checking bench for render_scheduler. A frame-level
//                reference model predicts, for each tick, the ordered list of
//                plotted pixels with their cycle offsets and the frame_done
//                offset; the bench compares the captured pixel stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_render_scheduler;
  import render_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           tick;
  logic [8*N-1:0] obj_x;
  logic [7*N-1:0] obj_y;
  logic [3*N-1:0] obj_size;
  logic [3*N-1:0] obj_colour;
  logic [2:0]     bg_colour;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           plot;
  logic           busy;
  logic           frame_done;

  render_scheduler #(.N_OBJ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_size   (obj_size),
    .obj_colour (obj_colour),
    .bg_colour  (bg_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Scene driven onto the DUT
  int tb_x[N], tb_y[N], tb_sz[N], tb_col[N];
  int tb_bg;

  // Model view of what is currently on screen
  int m_pv[N], m_x[N], m_y[N], m_sz[N];

  typedef struct {int x; int y; int c; int cyc;} pix_t;
  pix_t exp_q[$];
  pix_t got_q[$];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always_comb begin
    obj_x      = '0;
    obj_y      = '0;
    obj_size   = '0;
    obj_colour = '0;
    for (int k = 0; k < N; k++) begin
      obj_x[8*k +: 8]      = 8'(tb_x[k]);
      obj_y[7*k +: 7]      = 7'(tb_y[k]);
      obj_size[3*k +: 3]   = 3'(tb_sz[k]);
      obj_colour[3*k +: 3] = 3'(tb_col[k]);
    end
    bg_colour = 3'(tb_bg);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Appends one square's on-screen pixels; every pixel consumes a cycle.
  task automatic emit(input int x, input int y, input int s, input int col, inout int c);
    for (int py = 0; py < s; py++)
      for (int px = 0; px < s; px++) begin
        if (x + px < SCREEN_W && y + py < SCREEN_H)
          exp_q.push_back('{x + px, y + py, col, c});
        c++;
      end
  endtask

  // Cycle offsets counted from the tick cycle: LATCH at 1, then one select
  // cycle per object per pass plus size^2 per box, then DONE.
  task automatic model_frame(output int len);
    int c;
    bit chg;
    exp_q.delete();
    c = 2;
    for (int i = 0; i < N; i++) begin
      chg = (tb_x[i] != m_x[i]) || (tb_y[i] != m_y[i]) || (tb_sz[i] != m_sz[i]);
      c++;
      if (m_pv[i] != 0 && m_sz[i] != 0 && chg) emit(m_x[i], m_y[i], m_sz[i], tb_bg, c);
    end
    for (int i = 0; i < N; i++) begin
      chg = (tb_x[i] != m_x[i]) || (tb_y[i] != m_y[i]) || (tb_sz[i] != m_sz[i]);
      c++;
      if (tb_sz[i] != 0 && (m_pv[i] == 0 || chg)) emit(tb_x[i], tb_y[i], tb_sz[i], tb_col[i], c);
      m_pv[i] = 1;
      m_x[i]  = tb_x[i];
      m_y[i]  = tb_y[i];
      m_sz[i] = tb_sz[i];
    end
    len = c;
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0: ;
        1: tb_col[i] = $urandom_range(0, 7);
        default: begin
          tb_x[i]   = $urandom_range(0, 170);
          tb_y[i]   = $urandom_range(0, 124);
          tb_sz[i]  = $urandom_range(0, 7);
          tb_col[i] = $urandom_range(0, 7);
        end
      endcase
    end
    tb_bg = $urandom_range(0, 7);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_frame(input string name, input bit mid_change);
    int len, cnt, done_at, busy_low, n;
    model_frame(len);
    got_q.delete();
    done_at  = -1;
    busy_low = 0;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    cnt  = 1;
    while (cnt <= 700) begin
      if (busy !== 1'b1) busy_low = 1;
      if (plot === 1'b1) got_q.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour), cnt});
      if (frame_done === 1'b1) begin
        done_at = cnt;
        break;
      end
      if (mid_change && cnt == 3) scramble();
      @(posedge clk); #1;
      cnt++;
    end
    chk({name, ":frame_done_cycle"}, done_at, len);
    chk({name, ":busy_held"}, busy_low, 0);
    chk({name, ":plot_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      chk($sformatf("%s:pix%0d(x<<24|y<<16|c<<12|cyc)", name, k),
          (got_q[k].x << 24) | (got_q[k].y << 16) | (got_q[k].c << 12) | got_q[k].cyc,
          (exp_q[k].x << 24) | (exp_q[k].y << 16) | (exp_q[k].c << 12) | exp_q[k].cyc);
    @(posedge clk); #1;
    chk({name, ":idle_busy"}, busy, 0);
    chk({name, ":idle_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int len1, len2, n1, n2, cnt, dn, d1, d2, blow, np;

    reset = 1'b1;
    tick  = 1'b0;
    for (int i = 0; i < N; i++) begin
      tb_x[i] = 0; tb_y[i] = 0; tb_sz[i] = 0; tb_col[i] = 0;
      m_pv[i] = 0; m_x[i]  = 0; m_y[i]  = 0; m_sz[i]  = 0;
    end
    tb_bg = int'(BG_DEFAULT);
    repeat (3) @(posedge clk);
    #1;
    chk("reset:plot", plot, 0);
    chk("reset:busy", busy, 0);
    chk("reset:frame_done", frame_done, 0);
    chk("reset:vga_x", vga_x, 0);
    chk("reset:vga_y", vga_y, 0);
    chk("reset:vga_colour", vga_colour, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single player square, first frame: draws only, DONE 14 cycles in.
    tb_x[0] = 80; tb_y[0] = 100; tb_sz[0] = 2; tb_col[0] = 7;
    run_frame("first", 1'b0);

    tb_bg = 2;
    tb_x[0] = 79;
    run_frame("move", 1'b0);

    run_frame("unchanged", 1'b0);

    tb_col[0] = 3;
    run_frame("colour_only", 1'b0);

    tb_x[1] = 158; tb_y[1] = 118; tb_sz[1] = 3; tb_col[1] = 5;
    run_frame("clip", 1'b0);

    // Two extra ticks during a frame yield exactly one back-to-back frame.
    tb_x[0] = 60; tb_y[0] = 30;
    model_frame(len1);
    n1 = exp_q.size();
    model_frame(len2);
    n2 = exp_q.size();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    cnt = 1; dn = 0; d1 = -1; d2 = -1; blow = 0; np = 0;
    while (cnt <= 1500) begin
      if (busy !== 1'b1) blow = 1;
      if (plot === 1'b1) np++;
      if (frame_done === 1'b1) begin
        dn++;
        if (dn == 1) d1 = cnt;
        else         d2 = cnt;
      end
      if (dn == 2) break;
      tick = (cnt == 3 || cnt == 5);
      @(posedge clk); #1;
      cnt++;
    end
    tick = 1'b0;
    chk("pending:first_done", d1, len1);
    chk("pending:second_done", d2, len1 + len2);
    chk("pending:busy_gap", blow, 0);
    chk("pending:plots", np, n1 + n2);
    @(posedge clk); #1;
    chk("pending:idle_busy", busy, 0);
    chk("pending:idle_frame_done", frame_done, 0);

    // Randomised scenes, half of them with inputs changing mid-frame.
    for (int r = 0; r < 8; r++) begin
      scramble();
      run_frame($sformatf("rand%0d", r), r[0]);
    end

    // Asynchronous reset in the middle of a draw pass.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) m_pv[i] = 0;
    tb_x[0] = 10; tb_y[0] = 10; tb_sz[0] = 4; tb_col[0] = 1;
    tb_x[1] = 40; tb_y[1] = 20; tb_sz[1] = 3; tb_col[1] = 2;
    tb_x[2] = 90; tb_y[2] = 50; tb_sz[2] = 2; tb_col[2] = 4;
    tb_x[3] = 0;  tb_y[3] = 0;  tb_sz[3] = 0; tb_col[3] = 6;
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    cnt = 1;
    while (plot !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("areset:in_draw", plot, 1);
    reset = 1'b1;
    #1;
    chk("areset:plot", plot, 0);
    chk("areset:busy", busy, 0);
    chk("areset:frame_done", frame_done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_frame("after_reset", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
